// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: FETCH (req/ack) -> ISSUE (valid/ready) -> ADVANCE (one PC command), at least 3 cycles per instruction.
// Optional fetch watchdog under FETCH_TIMEOUT_EN; stalls on missing ack or ready simply extend the current state.
module fetch_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int INSTR_W     = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [1:0]         pc_control,
  output logic [ADDR_W-1:0]  branch_addr,
  output logic [ADDR_W-1:0]  jump_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic [3:0]         flags,
  output logic               halted,
  output logic               fetch_err
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_ISSUE   = 2'd1,
    S_ADVANCE = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_INC  = 2'b01;
  localparam logic [1:0] CMD_BR   = 2'b10;
  localparam logic [1:0] CMD_JMP  = 2'b11;

  localparam logic [INSTR_W-1:0] HALT_WORD = {{(INSTR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [INSTR_W-1:0]  instr_out_q, instr_out_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0]   branch_addr_q, branch_addr_d;
  logic [ADDR_W-1:0]   jump_addr_q, jump_addr_d;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_CYC - 1);
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       fetch_err_q, fetch_err_d;
`endif

  logic              is_halt;
  logic              is_jmp;
  logic              is_br;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jmp_target;

  // Decode of the held word; flags only matter on the ISSUE handshake cycle.
  assign is_halt    = (instr_out_q == HALT_WORD);
  assign is_jmp     = (instr_out_q[INSTR_W-1 -: 4] == 4'hF);
  assign is_br      = (instr_out_q[INSTR_W-1 -: 4] == 4'hE);
  assign br_taken   = (instr_out_q[11:8] == 4'h0) || ((instr_out_q[11:8] & flags) != 4'h0);
  assign br_target  = instr_pc_q + {{(ADDR_W-8){instr_out_q[7]}}, instr_out_q[7:0]};
  assign jmp_target = {instr_pc_q[ADDR_W-1 -: 4], instr_out_q[11:0]};

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    branch_addr_d = branch_addr_q;
    jump_addr_d   = jump_addr_q;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    fetch_err_d   = fetch_err_q;
`endif

    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_out_d = imem_rdata;
          instr_pc_d  = pc_in;
          state_d     = S_ISSUE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_LAST) begin
          fetch_err_d = 1'b1;
          state_d     = S_HALTED;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
`endif
      end

      S_ISSUE: begin
        if (instr_ready) begin
          if (is_halt) begin
            cmd_d   = CMD_HOLD;
            state_d = S_HALTED;
          end else begin
            state_d = S_ADVANCE;
            if (is_jmp) begin
              cmd_d       = CMD_JMP;
              jump_addr_d = jmp_target;
            end else if (is_br) begin
              cmd_d         = br_taken ? CMD_BR : CMD_INC;
              branch_addr_d = br_target;
            end else begin
              cmd_d = CMD_INC;
            end
          end
        end
      end

      S_ADVANCE: begin
        state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d = 4'd0;
`endif
      end

      S_HALTED: begin
        state_d = S_HALTED;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_FETCH;
      cmd_q         <= CMD_HOLD;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      branch_addr_q <= '0;
      jump_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      branch_addr_q <= branch_addr_d;
      jump_addr_q   <= jump_addr_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q  <= 4'd0;
      fetch_err_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // Reset state is FETCH, so the request is gated by reset_n to drop it while reset is held.
  assign imem_req    = reset_n && (state_q == S_FETCH);
  assign imem_addr   = imem_req ? pc_in : '0;
  assign instr_valid = (state_q == S_ISSUE);
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign pc_control  = (state_q == S_ADVANCE) ? cmd_q : CMD_HOLD;
  assign branch_addr = branch_addr_q;
  assign jump_addr   = jump_addr_q;
  assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: acts as program counter, instruction memory and decode; checks against a rule-level model.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset_n;
  logic [15:0] pc_in;
  logic [1:0]  pc_control;
  logic [15:0] branch_addr;
  logic [15:0] jump_addr;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic [3:0]  flags;
  logic        halted;
  logic        fetch_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] pc;
  logic [15:0] last_br;
  logic [15:0] last_jmp;
  logic        err_exp;

  fetch_sequencer #(.ADDR_W(16), .INSTR_W(16), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .pc_control(pc_control),
    .branch_addr(branch_addr), .jump_addr(jump_addr), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .flags(flags), .halted(halted), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic req, input logic vld, input logic [1:0] pcc, input logic hlt);
    check({tag, ".imem_req"}, 32'(imem_req), 32'(req));
    check({tag, ".instr_valid"}, 32'(instr_valid), 32'(vld));
    check({tag, ".pc_control"}, 32'(pc_control), 32'(pcc));
    check({tag, ".halted"}, 32'(halted), 32'(hlt));
    check({tag, ".fetch_err"}, 32'(fetch_err), 32'(err_exp));
    check({tag, ".branch_addr"}, 32'(branch_addr), 32'(last_br));
    check({tag, ".jump_addr"}, 32'(jump_addr), 32'(last_jmp));
  endtask

  function automatic logic [15:0] model_br(input logic [15:0] p, input logic [15:0] w);
    int off;
    off = (w[7:0] >= 8'd128) ? int'(w[7:0]) - 256 : int'(w[7:0]);
    return 16'((int'(p) + off + 65536) % 65536);
  endfunction

  function automatic logic [15:0] model_jmp(input logic [15:0] p, input logic [15:0] w);
    return (p & 16'hF000) | (w & 16'h0FFF);
  endfunction

  task automatic run_instr(input logic [15:0] w, input int ack_dly, input int rdy_dly, input logic [3:0] fl);
    logic [1:0] cmd;
    logic       taken;
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = 16'($urandom); instr_ready = 1'($urandom); flags = 4'($urandom);
      #1;
      cyc("fetch_wait", 1'b1, 1'b0, 2'b00, 1'b0);
      check("fetch_wait.imem_addr", 32'(imem_addr), 32'(pc));
    end
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = w; instr_ready = 1'($urandom);
    #1;
    cyc("fetch_ack", 1'b1, 1'b0, 2'b00, 1'b0);
    check("fetch_ack.imem_addr", 32'(imem_addr), 32'(pc));
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      imem_ack = 1'($urandom); imem_rdata = 16'($urandom); instr_ready = 1'b0; flags = 4'($urandom);
      #1;
      cyc("issue_wait", 1'b0, 1'b1, 2'b00, 1'b0);
      check("issue_wait.instr_out", 32'(instr_out), 32'(w));
      check("issue_wait.instr_pc", 32'(instr_pc), 32'(pc));
    end
    @(negedge clk);
    imem_ack = 1'($urandom); imem_rdata = 16'($urandom); instr_ready = 1'b1; flags = fl;
    #1;
    cyc("issue_hs", 1'b0, 1'b1, 2'b00, 1'b0);
    check("issue_hs.instr_out", 32'(instr_out), 32'(w));
    check("issue_hs.instr_pc", 32'(instr_pc), 32'(pc));

    @(negedge clk);
    imem_ack = 1'($urandom); instr_ready = 1'($urandom); flags = 4'($urandom);
    #1;
    if (w == 16'h0001) begin
      cyc("halt_entry", 1'b0, 1'b0, 2'b00, 1'b1);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        imem_ack = 1'($urandom); instr_ready = 1'($urandom);
        #1;
        cyc("halt_idle", 1'b0, 1'b0, 2'b00, 1'b1);
      end
    end else begin
      if (w[15:12] == 4'hF) begin
        cmd = 2'b11;
        last_jmp = model_jmp(pc, w);
        pc = last_jmp;
      end else if (w[15:12] == 4'hE) begin
        taken = (w[11:8] == 4'h0) || ((w[11:8] & fl) != 4'h0);
        last_br = model_br(pc, w);
        cmd = taken ? 2'b10 : 2'b01;
        pc = taken ? last_br : pc + 16'd1;
      end else begin
        cmd = 2'b01;
        pc = pc + 16'd1;
      end
      cyc("advance", 1'b0, 1'b0, cmd, 1'b0);
      pc_in = pc;
    end
  endtask

  task automatic release_reset(input logic [15:0] newpc);
    @(negedge clk);
    reset_n = 1'b1;
    pc = newpc; pc_in = newpc;
    last_br = 16'h0; last_jmp = 16'h0; err_exp = 1'b0;
    imem_ack = 1'b0;
    #1;
    check("release.imem_req", 32'(imem_req), 32'd1);
    check("release.imem_addr", 32'(imem_addr), 32'(newpc));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".imem_req"}, 32'(imem_req), 32'd0);
    check({tag, ".instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, ".pc_control"}, 32'(pc_control), 32'd0);
    check({tag, ".halted"}, 32'(halted), 32'd0);
    check({tag, ".fetch_err"}, 32'(fetch_err), 32'd0);
    check({tag, ".branch_addr"}, 32'(branch_addr), 32'd0);
    check({tag, ".jump_addr"}, 32'(jump_addr), 32'd0);
    check({tag, ".instr_out"}, 32'(instr_out), 32'd0);
    check({tag, ".instr_pc"}, 32'(instr_pc), 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] rnd;
    int          sel;

    reset_n = 1'b0; pc_in = 16'h0; imem_ack = 1'b0; imem_rdata = 16'h0;
    instr_ready = 1'b0; flags = 4'h0;
    pc = 16'h0; last_br = 16'h0; last_jmp = 16'h0; err_exp = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    instr_ready = 1'b1;
    #1;
    check_reset_outputs("reset");
    release_reset(16'h0000);

    // Sequential fetch, minimum 3-cycle loop
    run_instr(16'h1234, 0, 0, 4'h0);
    run_instr(16'h5678, 0, 0, 4'h0);

    // Taken and not-taken branch
    pc = 16'h0010; pc_in = pc;
    run_instr(16'hE1FC, 0, 0, 4'b0001);
    check("dir_br_taken.branch_addr", 32'(branch_addr), 32'h000C);
    check("dir_br_taken.pc_control", 32'(pc_control), 32'h2);
    pc = 16'h0010; pc_in = pc;
    run_instr(16'hE1FC, 0, 0, 4'b0000);
    check("dir_br_not_taken.pc_control", 32'(pc_control), 32'h1);

    // Jump and wrapping branch
    pc = 16'h3000; pc_in = pc;
    run_instr(16'hFABC, 0, 0, 4'h0);
    check("dir_jmp.jump_addr", 32'(jump_addr), 32'h3ABC);
    check("dir_jmp.pc_control", 32'(pc_control), 32'h3);
    pc = 16'hFFF0; pc_in = pc;
    run_instr(16'hE07F, 0, 0, 4'h0);
    check("dir_wrap.branch_addr", 32'(branch_addr), 32'h006F);
    pc = 16'h0003; pc_in = pc;
    run_instr(16'hE080, 0, 0, 4'h0);
    check("dir_wrap_down.branch_addr", 32'(branch_addr), 32'hFF83);

    // Backpressure on both handshakes
    run_instr(16'h2222, 4, 3, 4'h0);

    // Randomized instruction mix
    for (int n = 0; n < 40; n++) begin
      rnd = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 3)      w = {4'hE, rnd[11:0]};
      else if (sel < 5) w = {4'hF, rnd[11:0]};
      else begin
        w = {4'($urandom_range(0, 13)), rnd[11:0]};
        if (w == 16'h0001) w = 16'h0002;
      end
      run_instr(w, $urandom_range(0, 5), $urandom_range(0, 3), 4'($urandom));
    end

    // Reset mid-fetch
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    check("mid_fetch.imem_req", 32'(imem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_fetch_rst");
    release_reset(16'h0100);
    run_instr(16'h0ABC, 1, 0, 4'h0);

    // Reset mid-issue
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 16'h4321; instr_ready = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    check("mid_issue.instr_valid", 32'(instr_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_issue_rst");
    release_reset(16'h0200);
    run_instr(16'h7777, 0, 1, 4'h0);

    // Halt, then reset recovers
    run_instr(16'h0001, 0, 2, 4'hF);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("halt_rst");
    release_reset(16'h0400);
    run_instr(16'h1111, 0, 0, 4'h0);

`ifdef FETCH_TIMEOUT_EN
    // Ack on the 15th cycle is still accepted
    run_instr(16'h3333, 14, 0, 4'h0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      #1;
      cyc("timeout_wait", 1'b1, 1'b0, 2'b00, 1'b0);
    end
    @(negedge clk);
    imem_ack = 1'b1;
    err_exp = 1'b1;
    #1;
    cyc("timeout_err", 1'b0, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imem_ack = 1'($urandom);
      #1;
      cyc("timeout_idle", 1'b0, 1'b0, 2'b00, 1'b1);
    end
`else
    // Without the watchdog a long wait is just a stall
    run_instr(16'h3333, 20, 0, 4'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch control unit that drives the program counter: reads the current PC, fetches the instruction word from instruction memory over a req/ack handshake, and hands it to decode over a valid/ready handshake. It then resolves sequential, branch and jump flow and issues exactly one PC command per instruction on the PC's `pc_control` / `branch_addr` / `jump_addr` inputs. It sits between the program counter, instruction memory and the decode stage.

## Interface
- `ADDR_W`, 16, PC and memory address width (the PC is fixed at 16).
- `INSTR_W`, 16, instruction word width.
- `TIMEOUT_CYC`, 15, fetch wait limit in cycles; used only with `FETCH_TIMEOUT_EN`.

Ports:
- `clk` input 1: clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `pc_in` input ADDR_W: current PC value from the program counter.
- `pc_control` output 2: PC command. 00 hold, 01 increment, 10 branch, 11 jump.
- `branch_addr` output ADDR_W: branch target.
- `jump_addr` output ADDR_W: jump target.
- `imem_req` output 1: fetch request.
- `imem_addr` output ADDR_W: fetch address.
- `imem_ack` input 1: memory returns `imem_rdata` this cycle.
- `imem_rdata` input INSTR_W: fetched word.
- `instr_valid` output 1: instruction offered to decode.
- `instr_out` output INSTR_W: held instruction.
- `instr_pc` output ADDR_W: address of `instr_out`.
- `instr_ready` input 1: decode accepts.
- `flags` input 4: condition flags from the ALU.
- `halted` output 1: sequencer stopped.
- `fetch_err` output 1: sticky fetch timeout.

## Operation
States: FETCH, ISSUE, ADVANCE, HALTED.

- **Reset:** state FETCH. All outputs are 0: `pc_control`=00, `branch_addr`=0, `jump_addr`=0, `instr_out`=0, `instr_pc`=0, `instr_valid`=0, `halted`=0, `fetch_err`=0. `imem_req` asserts on the first cycle after reset release.
- **FETCH:**
  - `imem_req`=1 and `imem_addr`=`pc_in`, both combinational from state.
  - On a cycle with `imem_ack`=1: latch `imem_rdata` to `instr_out` and `pc_in` to `instr_pc`, then go to ISSUE.
  - `imem_ack` is ignored in every other state.
- **ISSUE:** `instr_valid`=1. On a cycle with `instr_ready`=1, classify `instr_out` and register the PC command for the next cycle:
  - 16'h0001 (HALT): command 00, then HALTED. `instr_valid` still handshakes.
  - Opcode [15:12]=4'hF (JMP): command 11, `jump_addr` = {`instr_pc`[15:12], `instr_out`[11:0]}.
  - Opcode 4'hE (BR): `branch_addr` = `instr_pc` + sign-extended `instr_out`[7:0], modulo 2^16 (wraps in both directions). The branch is taken when `instr_out`[11:8]==0 or (`instr_out`[11:8] & `flags`)!=0; command 10 if taken, else 01.
  - Any other word: command 01.
  - `flags` is sampled only on the handshake cycle.
- **ADVANCE:** `pc_control` holds the registered command for exactly one cycle, so the PC updates at the end of this cycle. Then go to FETCH.
  - `branch_addr` and `jump_addr` hold their last values outside ADVANCE.
- **HALTED:** `halted`=1, `pc_control`=00, no requests. Only reset exits.
- `pc_control` is 00 in every state except ADVANCE.

## Timing
- Minimum time per instruction is 3 cycles: FETCH with same-cycle ack, ISSUE with ready, ADVANCE.
- Each extra cycle without `imem_ack` or without `instr_ready` adds one cycle.
- `instr_out` and `instr_pc` are stable from ISSUE entry until the handshake.
- `instr_valid` drops the cycle after acceptance.
- Reset asserted mid-fetch or mid-issue drops `imem_req`, `instr_valid` and `pc_control` immediately (asynchronously). After release, operation restarts in FETCH at whatever `pc_in` then holds.
- `instr_ready` held high while `instr_valid`=0 has no effect.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A 4-bit wait counter clears on FETCH entry and increments each FETCH cycle without `imem_ack`.
  - When the counter reaches `TIMEOUT_CYC` without an ack: set `fetch_err`=1 (sticky until reset), `halted`=1, and go to HALTED.
  - An ack on the same cycle the count reaches `TIMEOUT_CYC` wins: normal latch, no error.
- `FETCH_TIMEOUT_EN` undefined: FETCH waits indefinitely, `fetch_err` is tied to 0, and the counter is not built.

## Test plan
- **Sequential fetch:** reset, `pc_in`=0, `imem_ack` same cycle with 16'h1234, `instr_ready`=1 → `instr_valid` one cycle with `instr_pc`=0; `pc_control`=01 for exactly one cycle; a 3-cycle loop repeats.
- **Taken branch:** `instr_pc`=16'h0010, word 16'hE1FC, `flags`=4'b0001 → `branch_addr`=16'h000C, `pc_control`=10 for one cycle. Same word with `flags`=0 → `pc_control`=01.
- **Jump and wrap:** word 16'hFABC at `instr_pc`=16'h3000 → `jump_addr`=16'h3ABC, `pc_control`=11. Word 16'hE07F at `instr_pc`=16'hFFF0 → `branch_addr`=16'h006F.
- **Backpressure and wait:** ack delayed 4 cycles, `instr_ready` low for 3 cycles → `imem_req` high for 5 cycles, `instr_out` stable during the wait, `pc_control`=00 throughout, then a single command.
- **Halt and reset:** word 16'h0001 → `halted`=1, `imem_req`=0 forever. `reset_n` pulsed low → all outputs 0 immediately, fetch resumes after release.
- **Timeout (`FETCH_TIMEOUT_EN` defined):** no `imem_ack` for 15 cycles → `fetch_err`=1, `halted`=1. Ack on cycle 15 → no error.
